// File: rtl/alu_seq_unit.sv
// alu_seq_unit: request/response ALU with a bit-serial shifter.
// Arithmetic, logic and branch ops finish one cycle after accept. SLL/SRL
// shift one bit per cycle unless ALU_FAST_SHIFT_EN is defined, in which case
// they use a single-cycle barrel shift and the SHIFT state and counter go away.
// The result is held in DONE until the consumer takes it.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLL  4'd5
`define ALU_SRL  4'd6
`define ALU_BEQ  4'd7
`define ALU_BNE  4'd8
`define ALU_BLT  4'd9
`define ALU_BGE  4'd10
`define ALU_ZERO 4'd11
`endif

module alu_seq_unit #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_in_1,
   input  logic [DATA_W-1:0] alu_in_2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_result,
   output logic              alu_bcond
);

`ifdef ALU_FAST_SHIFT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t              state, state_n;
   logic [DATA_W-1:0]   res_n;
   logic                bc_n;
   logic [SHAMT_W-1:0]  shamt;

`ifndef ALU_FAST_SHIFT_EN
   logic [DATA_W-1:0]   acc, acc_n;
   logic [SHAMT_W-1:0]  cnt, cnt_n;
   logic                dir_left, dir_left_n;
`endif

   assign shamt     = alu_in_2[SHAMT_W-1:0];
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Next state and next datapath values; everything holds unless updated.
   always_comb begin
      state_n = state;
      res_n   = alu_result;
      bc_n    = alu_bcond;
`ifndef ALU_FAST_SHIFT_EN
      acc_n      = acc;
      cnt_n      = cnt;
      dir_left_n = dir_left;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = DONE;
               res_n   = '0;
               bc_n    = 1'b0;
               case (alu_op)
                  `ALU_ADD: res_n = alu_in_1 + alu_in_2;
                  `ALU_SUB: res_n = alu_in_1 - alu_in_2;
                  `ALU_AND: res_n = alu_in_1 & alu_in_2;
                  `ALU_OR:  res_n = alu_in_1 | alu_in_2;
                  `ALU_XOR: res_n = alu_in_1 ^ alu_in_2;
`ifdef ALU_FAST_SHIFT_EN
                  `ALU_SLL: res_n = alu_in_1 << shamt;
                  `ALU_SRL: res_n = alu_in_1 >> shamt;
`else
                  `ALU_SLL, `ALU_SRL: begin
                     if (shamt == '0) begin
                        res_n = alu_in_1;
                     end else begin
                        // Serial path: outputs keep the previous result until DONE.
                        state_n    = SHIFT;
                        res_n      = alu_result;
                        bc_n       = alu_bcond;
                        acc_n      = alu_in_1;
                        cnt_n      = shamt;
                        dir_left_n = (alu_op == `ALU_SLL);
                     end
                  end
`endif
                  `ALU_BEQ: bc_n = (alu_in_1 == alu_in_2);
                  `ALU_BNE: bc_n = (alu_in_1 != alu_in_2);
                  `ALU_BLT: bc_n = ($signed(alu_in_1) <  $signed(alu_in_2));
                  `ALU_BGE: bc_n = ($signed(alu_in_1) >= $signed(alu_in_2));
                  default:  ;
               endcase
            end
         end
`ifndef ALU_FAST_SHIFT_EN
         SHIFT: begin
            acc_n = dir_left ? (acc << 1) : (acc >> 1);
            cnt_n = cnt - 1'b1;
            if (cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
               state_n = DONE;
               res_n   = acc_n;
               bc_n    = 1'b0;
            end
         end
`endif
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers; reset overrides any in-flight work.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         alu_result <= '0;
         alu_bcond  <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
         acc        <= '0;
         cnt        <= '0;
         dir_left   <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         alu_result <= res_n;
         alu_bcond  <= bc_n;
`ifndef ALU_FAST_SHIFT_EN
         acc        <= acc_n;
         cnt        <= cnt_n;
         dir_left   <= dir_left_n;
`endif
      end
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed corner cases followed by random ops,
// all compared against a behavioural model of the ALU rules.
module tb_alu_seq_unit;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_BEQ = 4'd7,
                          OP_BNE = 4'd8, OP_BLT = 4'd9, OP_BGE = 4'd10, OP_ZERO = 4'd11;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic        in_ready, out_valid, alu_bcond;
   logic [3:0]  alu_op;
   logic [31:0] alu_in_1, alu_in_2, alu_result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_seq_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_result(alu_result), .alu_bcond(alu_bcond)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: result, branch flag and accept-to-valid latency from the op rules.
   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic bc, output int lat);
      int k;
      k   = int'(b % 32);
      r   = 0;
      bc  = 0;
      lat = 1;
      case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLL, OP_SRL: begin
            r = (op == OP_SLL) ? (a << k) : (a >> k);
`ifndef ALU_FAST_SHIFT_EN
            if (k > 0) lat = k + 1;
`endif
         end
         OP_BEQ: bc = (a == b);
         OP_BNE: bc = (a != b);
         OP_BLT: bc = ($signed(a) <  $signed(b));
         OP_BGE: bc = ($signed(a) >= $signed(b));
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
      logic [31:0] er;
      logic        ebc;
      int          lat, cyc;
      model(op, a, b, er, ebc, lat);
      @(negedge clk);
      chk("ready_before", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; alu_op = op; alu_in_1 = a; alu_in_2 = b; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; alu_op = 4'($urandom); alu_in_1 = $urandom; alu_in_2 = $urandom;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         chk("ready_busy", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
         cyc++;
      end
      chk("latency", cyc, lat);
      chk("result", alu_result, er);
      chk("bcond", {31'b0, alu_bcond}, {31'b0, ebc});
      chk("ready_done", {31'b0, in_ready}, 32'd0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_result", alu_result, er);
         chk("hold_bcond", {31'b0, alu_bcond}, {31'b0, ebc});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
      chk("idle_ready", {31'b0, in_ready}, 32'd1);
      chk("idle_result", alu_result, er);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      int          seen;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      alu_op = '0; alu_in_1 = '0; alu_in_2 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", alu_result, 32'd0);
      chk("rst_bcond", {31'b0, alu_bcond}, 32'd0);

      // Directed corners
      run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 0);
      run_op(OP_SRL, 32'h8000_0000, 32'h1F, 0);
      run_op(OP_BLT, 32'hFFFF_FFFF, 32'h1, 0);
      run_op(OP_BGE, 32'hFFFF_FFFF, 32'h1, 0);
      run_op(OP_SUB, 32'd5, 32'd7, 4);
      run_op(OP_SLL, 32'h1234_5678, 32'h20, 0);
      run_op(OP_SLL, 32'h1, 32'h1, 1);
      run_op(OP_ZERO, 32'hDEAD_BEEF, 32'h1, 0);
      run_op(4'd15, 32'hDEAD_BEEF, 32'h1, 0);
      run_op(OP_BEQ, 32'h55, 32'h55, 0);
      run_op(OP_BNE, 32'h55, 32'h55, 0);

      // Reset while a shift is in flight: op is dropped, no out_valid pulse
      @(negedge clk);
      in_valid = 1'b1; alu_op = OP_SLL; alu_in_1 = 32'h1; alu_in_2 = 32'h10; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0;
      repeat (2) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      if (out_valid) seen++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
      seen = 0;
`endif
      chk("rst_inflight_novalid", seen, 0);
      chk("rst_inflight_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_inflight_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_inflight_result", alu_result, 32'd0);
      repeat (20) begin
         @(posedge clk); #1;
         chk("rst_quiet", {31'b0, out_valid}, 32'd0);
      end
      out_ready = 1'b0;

      // Random ops
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 1) == 0) rb = {$urandom_range(0, 3), 27'b0, 5'($urandom_range(0, 6))};
         run_op(rop, ra, rb, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_seq_unit.md
ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width.
REQ-002 SHALL have parameter: SHAMT_W, 5, shift-amount width taken from alu_in_2[SHAMT_W-1:0].
REQ-003 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  operation request from ALU control/operand stage.
REQ-006 SHALL have port: in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port: alu_op  input  4  operation code, `ALU_* encodings from alu_opcodes.v.
REQ-008 SHALL have port: alu_in_1  input  DATA_W  operand A (rs1).
REQ-009 SHALL have port: alu_in_2  input  DATA_W  operand B (rs2 or immediate).
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: alu_result  output  DATA_W  computed result.
REQ-013 SHALL have port: alu_bcond  output  1  branch-condition outcome.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready, capturing alu_op and both operands; inputs SHALL be ignored in all other cycles.
REQ-016 ADD/SUB SHALL be modulo 2^DATA_W; AND/OR/XOR bitwise; result latched on accept, next state DONE (out_valid one cycle after accept).
REQ-017 SLL/SRL SHALL shift alu_in_1 by k = alu_in_2[SHAMT_W-1:0]; SRL logical (zero fill); upper operand-B bits ignored.
REQ-018 Shift with k==0 SHALL go directly to DONE with alu_result = alu_in_1.
REQ-019 Shift with k>=1 SHALL enter SHIFT with accumulator = alu_in_1, counter = k; each SHIFT cycle shifts accumulator by one bit and decrements counter; the edge where counter==1 moves to DONE; out_valid rises k+1 cycles after accept.
REQ-020 BEQ/BNE/BLT/BGE SHALL set alu_bcond to A==B, A!=B, signed A<B, signed A>=B respectively, alu_result = 0, next state DONE.
REQ-021 alu_bcond SHALL be 0 for all non-branch ops.
REQ-022 ALU_ZERO and any unlisted code SHALL yield alu_result = 0, alu_bcond = 0, next state DONE.
REQ-023 In DONE, alu_result and alu_bcond SHALL hold stable until out_valid && out_ready; that edge returns to IDLE (no same-cycle re-accept; back-to-back throughput one op per 2 cycles minimum).
REQ-024 alu_result and alu_bcond SHALL be registered outputs; values outside DONE SHALL be the last completed result (0 after reset).

Reset
REQ-025 reset high at a rising edge SHALL force state IDLE, accumulator/counter/alu_result/alu_bcond to 0, out_valid 0, in_ready 1 from the next cycle.
REQ-026 reset SHALL take priority over accept, shift progress and handoff; an in-flight op SHALL be discarded with no out_valid pulse.

Configuration
REQ-027 Macro ALU_FAST_SHIFT_EN defined: SLL/SRL SHALL complete in a single combinational barrel shift like REQ-016 (out_valid one cycle after accept); SHIFT state and counter SHALL be absent.
REQ-028 Macro ALU_FAST_SHIFT_EN undefined: shifts SHALL follow REQ-018/REQ-019 serial behaviour.

Verification
REQ-029 ADD A=0xFFFFFFFF, B=0x1, out_ready=1 -> out_valid next cycle, alu_result=0x00000000, alu_bcond=0.
REQ-030 SRL A=0x80000000, B=0x1F (serial) -> out_valid 32 cycles after accept, alu_result=0x00000001; in_ready low throughout; with ALU_FAST_SHIFT_EN -> 1 cycle.
REQ-031 BLT A=0xFFFFFFFF, B=0x1 -> alu_bcond=1, alu_result=0; BGE same operands -> alu_bcond=0.
REQ-032 SUB A=5, B=7, out_ready held 0 for 4 cycles -> out_valid and alu_result=0xFFFFFFFE stable all 4 cycles, IDLE the cycle after out_ready=1.
REQ-033 SLL A=0x1, B=0x10, reset asserted 3 cycles after accept -> no out_valid, next cycle in_ready=1, alu_result=0.
REQ-034 SLL with B=0x20 (k=0) -> alu_result=A, out_valid one cycle after accept.
